// File: rtl/fc_relu_pack_if.sv
// fc_relu_pack_if -- row input and packed-word output bundle for fc_relu_pack.
//   in_valid, in1..in4 : one signed 16-bit result row from the matrix engine
//   out_data, out_valid, out_last, out_ready : first-word-fall-through word stream
// Modports: slave = the packing block, master = the side that feeds rows and consumes words.
interface fc_relu_pack_if;
  logic               in_valid;
  logic signed [15:0] in1;
  logic signed [15:0] in2;
  logic signed [15:0] in3;
  logic signed [15:0] in4;
  logic [31:0]        out_data;
  logic               out_valid;
  logic               out_last;
  logic               out_ready;

  modport slave (
    input  in_valid, in1, in2, in3, in4, out_ready,
    output out_data, out_valid, out_last
  );

  modport master (
    output in_valid, in1, in2, in3, in4, out_ready,
    input  out_data, out_valid, out_last
  );
endinterface

// File: rtl/fc_relu_pack.sv
// fc_relu_pack -- applies ReLU, an arithmetic right shift and unsigned 8-bit
// saturation to each element of a 4-wide result row, packs the row into a
// 32-bit word {e1,e2,e3,e4} and buffers it in a first-word-fall-through FIFO
// tagged with an end-of-tile marker (every 4th row).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : fc_relu_pack_if.slave (row input, word output handshake)
//   clr_flags  : synchronous clear of the sticky ovf/sat flags
//   ovf        : sticky, a row was dropped because the FIFO was full
//   sat        : sticky, an element was clipped to 255
//   level      : current FIFO occupancy
module fc_relu_pack #(
  parameter int SHIFT = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fc_relu_pack_if.slave          bus,
  input  logic                   clr_flags,
  output logic                   ovf,
  output logic                   sat,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  // Element processing
  logic signed [15:0] elem_in [4];
  logic [7:0]         elem_out [4];
  logic [3:0]         elem_sat;

  assign elem_in[0] = bus.in1;
  assign elem_in[1] = bus.in2;
  assign elem_in[2] = bus.in3;
  assign elem_in[3] = bus.in4;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_elem
      logic signed [15:0] shifted;
      logic [7:0]         res;
      logic               hi;

      assign shifted = elem_in[gi] >>> SHIFT;

      always_comb begin
        res = 8'd0;
        hi  = 1'b0;
        if (elem_in[gi][15]) begin
          res = 8'd0;
        end else if (shifted > 16'sd255) begin
          res = 8'hFF;
          hi  = 1'b1;
        end else begin
          res = shifted[7:0];
        end
      end

      assign elem_out[gi] = res;
      assign elem_sat[gi] = hi;
    end
  endgenerate

  logic [31:0] packed_word;
  assign packed_word = {elem_out[0], elem_out[1], elem_out[2], elem_out[3]};

  // FIFO state
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [1:0]    row_cnt_reg;
  logic          ovf_reg;
  logic          sat_reg;

  logic pop;
  logic push;
  logic drop;

  assign pop  = (level_reg != '0) && bus.out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push = bus.in_valid && ((level_reg < FULL_LEVEL) || pop);
  assign drop = bus.in_valid && !push;

  // Storage has no reset; only the pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {(row_cnt_reg == 2'd3), packed_word};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      row_cnt_reg <= 2'd0;
      ovf_reg     <= 1'b0;
      sat_reg     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
      // Row counter follows every presented row so dropped rows keep tiles aligned.
      if (bus.in_valid) begin
        row_cnt_reg <= row_cnt_reg + 2'd1;
      end
      if (clr_flags) begin
        ovf_reg <= 1'b0;
        sat_reg <= 1'b0;
      end else begin
        if (drop) begin
          ovf_reg <= 1'b1;
        end
        if (bus.in_valid && (elem_sat != 4'd0)) begin
          sat_reg <= 1'b1;
        end
      end
    end
  end

  // Fall-through head, forced to zero while empty.
  logic [32:0] head;
  assign head = mem[rd_ptr_reg];

  assign bus.out_valid = (level_reg != '0);
  assign bus.out_data  = bus.out_valid ? head[31:0] : 32'd0;
  assign bus.out_last  = bus.out_valid ? head[32] : 1'b0;
  assign level         = level_reg;
  assign ovf           = ovf_reg;
  assign sat           = sat_reg;

endmodule
